// File: rtl/stoch_reservoir_pkg.sv
// Shared types and constants for the stochastic reservoir: FSM states,
// Galois LFSR taps per supported word width, and a parameter sanity check.
package stoch_reservoir_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      UPDATE = 2'd2
   } state_t;

   // Right-shifting Galois taps for maximal-length sequences
   localparam logic [31:0] TAPS_W8  = 32'h0000_00B8;
   localparam logic [31:0] TAPS_W12 = 32'h0000_0E08;
   localparam logic [31:0] TAPS_W16 = 32'h0000_B400;
   localparam logic [31:0] TAPS_W24 = 32'h00E1_0000;
   localparam logic [31:0] TAPS_W32 = 32'hA300_0000;

   function automatic logic [31:0] lfsr_taps(input int w);
      case (w)
         8:       return TAPS_W8;
         12:      return TAPS_W12;
         16:      return TAPS_W16;
         24:      return TAPS_W24;
         32:      return TAPS_W32;
         default: return 32'h0;
      endcase
   endfunction

   function automatic bit cfg_ok(input int w, input int win_log2, input int n_nodes);
      return (lfsr_taps(w) != 32'h0) && (win_log2 >= 1) && (win_log2 <= w) && (n_nodes >= 2);
   endfunction

endpackage

// File: rtl/stoch_reservoir_if.sv
// Start/done handshake, step operands and neuron state bus of the reservoir.
interface stoch_reservoir_if #(
   parameter int N_NODES = 20,
   parameter int W       = 16
);
   logic                 start;
   logic                 clear;
   logic [W-1:0]         u_t;
   logic [W-1:0]         r_cfg;
   logic [W-1:0]         v_cfg;
   logic [W-1:0]         seed;
   logic                 busy;
   logic                 done;
   logic [N_NODES*W-1:0] state_out;

   modport master (
      output start, clear, u_t, r_cfg, v_cfg, seed,
      input  busy, done, state_out
   );

   modport slave (
      input  start, clear, u_t, r_cfg, v_cfg, seed,
      output busy, done, state_out
   );
endinterface

// File: rtl/stoch_node.sv
// One reservoir neuron: mixes the shared stream bits into its output bit,
// counts it over the window and rescales the count into its next state.
// Optional leaky integration of the state is enabled by RESERVOIR_LEAK_EN.
module stoch_node
   import stoch_reservoir_pkg::*;
#(
   parameter int W        = 16,
   parameter int WIN_LOG2 = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         acc_clr,
   input  logic         acc_en,
   input  logic         upd_en,
   input  logic         x_clr,
   input  logic         u_bit,
   input  logic         r_bit,
   input  logic         vw_bit,
   input  logic         x_prev_bit,
   output logic [W-1:0] x
);

   localparam int                SH   = W - WIN_LOG2;
   localparam logic [WIN_LOG2:0] FULL = {1'b1, {WIN_LOG2{1'b0}}};

   logic [WIN_LOG2:0] acc_q;
   logic [W-1:0]      x_q;
   logic [W-1:0]      acc_w;
   logic [W-1:0]      scaled;
   logic [W-1:0]      x_next;
   logic              b;

   assign b      = r_bit ? (vw_bit & x_prev_bit) : u_bit;
   assign acc_w  = W'(acc_q);
   assign scaled = (acc_q == FULL) ? {W{1'b1}} : (acc_w << SH);

`ifdef RESERVOIR_LEAK_EN
   logic [W:0] leak_sum;
   assign leak_sum = {1'b0, x_q} + {1'b0, scaled};
   assign x_next   = leak_sum[W:1];
`else
   assign x_next   = scaled;
`endif

   // NOTE: non-blocking updates so every node samples its neighbour's pre-edge x.
   // NOTE: acc and x are plain flops, not a RAM, so they take the async reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         x_q   <= '0;
      end else begin
         if (acc_clr)
            acc_q <= '0;
         else if (acc_en)
            acc_q <= acc_q + {{WIN_LOG2{1'b0}}, b};

         if (x_clr)
            x_q <= '0;
         else if (upd_en)
            x_q <= x_next;
      end
   end

   assign x = x_q;

endmodule

// File: rtl/stoch_reservoir_core.sv
// Stochastic-computing reservoir ring: FSM, window counter, shared LFSR and
// stream comparators; per-neuron state lives in stoch_node. Leak option: RESERVOIR_LEAK_EN.
module stoch_reservoir_core
   import stoch_reservoir_pkg::*;
#(
   parameter int N_NODES  = 20,
   parameter int W        = 16,
   parameter int WIN_LOG2 = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   stoch_reservoir_if.slave  bus
);

   if (!cfg_ok(W, WIN_LOG2, N_NODES)) begin : g_bad_cfg
      $error("stoch_reservoir_core: unsupported W, WIN_LOG2 or N_NODES");
   end

   localparam logic [W-1:0] TAPS = W'(lfsr_taps(W));
   localparam int           Q1   = W / 4;
   localparam int           Q2   = W / 2;
   localparam int           Q3   = (3 * W) / 4;

   state_t              state_q, state_d;
   logic [WIN_LOG2-1:0] cnt_q;
   logic [W-1:0]        lfsr_q;
   logic [W-1:0]        lfsr_next;
   logic [W-1:0]        u_q, r_q, v_q;
   logic                done_q;

   logic                accept;
   logic                clear_x;
   logic                run;
   logic                upd;
   logic [W-1:0]        p0, p1, p2, p3;
   logic                u_bit, r_bit, v_bit;
   logic [N_NODES-1:0]  x_bit;
   logic [W-1:0]        x [N_NODES];

   assign accept  = (state_q == IDLE) && bus.start;
   assign clear_x = (state_q == IDLE) && bus.clear;
   assign run     = (state_q == RUN);
   assign upd     = (state_q == UPDATE);

   // NOTE: defaults first so every path assigns state_d and no latch is inferred.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start) state_d = RUN;
         RUN:     if (cnt_q == {WIN_LOG2{1'b1}}) state_d = UPDATE;
         UPDATE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign lfsr_next = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : {W{1'b0}});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         lfsr_q  <= {{(W-1){1'b0}}, 1'b1};
         u_q     <= '0;
         r_q     <= '0;
         v_q     <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= upd;
         if (accept) begin
            u_q    <= bus.u_t;
            r_q    <= bus.r_cfg;
            v_q    <= bus.v_cfg;
            lfsr_q <= (bus.seed == '0) ? {{(W-1){1'b0}}, 1'b1} : bus.seed;
            cnt_q  <= '0;
         end else if (run) begin
            lfsr_q <= lfsr_next;
            cnt_q  <= cnt_q + 1'b1;
         end
      end
   end

   // Rotated views decorrelate the four streams drawn from one LFSR
   assign p0 = lfsr_q;
   assign p1 = {lfsr_q[W-Q1-1:0], lfsr_q[W-1:W-Q1]};
   assign p2 = {lfsr_q[W-Q2-1:0], lfsr_q[W-1:W-Q2]};
   assign p3 = {lfsr_q[W-Q3-1:0], lfsr_q[W-1:W-Q3]};

   assign u_bit = (p0 <= u_q);
   assign r_bit = (p1 <= r_q);
   assign v_bit = (p2 <= v_q);

   for (genvar k = 0; k < N_NODES; k++) begin : g_node
      localparam int PREV   = (k == 0) ? N_NODES - 1 : k - 1;
      localparam bit VW_INV = (k >= 2) && ((k % 2) == 0);

      assign x_bit[k] = (p3 <= x[k]);

      stoch_node #(
         .W        (W),
         .WIN_LOG2 (WIN_LOG2)
      ) u_node (
         .clk        (clk),
         .rst_n      (rst_n),
         .acc_clr    (accept),
         .acc_en     (run),
         .upd_en     (upd),
         .x_clr      (clear_x),
         .u_bit      (u_bit),
         .r_bit      (r_bit),
         .vw_bit     (VW_INV ? ~v_bit : v_bit),
         .x_prev_bit (x_bit[PREV]),
         .x          (x[k])
      );

      assign bus.state_out[k*W +: W] = x[k];
   end

   assign bus.busy = (state_q != IDLE);
   assign bus.done = done_q;

endmodule
